// File: rtl/fetch_decode.sv
// fetch_decode
// ------------
// Instruction fetch and decode front end. The block issues sequential fetch
// addresses to a synchronous instruction ROM, splits each returned 9-bit
// instruction into a 5-bit opcode and a 4-bit operand field, and presents the
// result on a registered output stage backed by a 1-entry skid buffer.
// Redirects from execute override everything in RUN. An illegal opcode (27..31)
// stops fetching and raises a sticky halt flag.
//
// Handshake: out_valid/stall follow valid/ready semantics with stall as the
// inverted ready. A transfer happens in any cycle where out_valid=1 and
// stall=0. While out_valid=1 and stall=1 the output registers do not change.
// out_valid never drops without a transfer, except on a redirect, a restart
// from HALT, or reset.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-high reset
//   start       in   begin fetching at START_PC from IDLE or HALT
//   imem_addr   out  [PC_W-1:0] ROM address (the internal pc)
//   imem_rdata  in   [8:0] ROM data, valid one cycle after the address
//   br_taken    in   redirect request (RUN only)
//   br_target   in   [PC_W-1:0] redirect address
//   stall       in   downstream not accepting
//   out_valid   out  decoded instruction present
//   out_op      out  [4:0] opcode, imem_rdata[8:4]
//   out_field   out  [3:0] operand field, imem_rdata[3:0]
//   out_pc      out  [PC_W-1:0] fetch address of the presented instruction
//   halt        out  sticky illegal-opcode flag
//   dbg_state   out  [1:0] FSM state for observation

module fetch_decode #(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    input  logic [8:0]      imem_rdata,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            stall,
    output logic            out_valid,
    output logic [4:0]      out_op,
    output logic [3:0]      out_field,
    output logic [PC_W-1:0] out_pc,
    output logic            halt,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [PC_W-1:0] r_pc;
    logic            r_pending;
    logic [PC_W-1:0] r_pend_pc;

    logic            r_skid_valid;
    logic [4:0]      r_skid_op;
    logic [3:0]      r_skid_field;
    logic [PC_W-1:0] r_skid_pc;

    logic            r_out_valid;
    logic [4:0]      r_out_op;
    logic [3:0]      r_out_field;
    logic [PC_W-1:0] r_out_pc;
    logic            r_halt;

    logic w_ret_illegal;
    logic w_ret_ok;
    logic w_xfer;
    logic w_out_free;
    logic w_load_start;
    logic w_redirect;
    logic w_issue;
    logic w_go_halt;
    logic w_flush;

    // r_pending is only ever set in RUN, so a return can only arrive there.
    assign w_ret_illegal = r_pending && (imem_rdata[8:4] >= 5'd27);
    assign w_ret_ok      = r_pending && !w_ret_illegal;
    assign w_xfer        = r_out_valid && !stall;
    assign w_out_free    = !r_out_valid || w_xfer;
    assign w_flush       = w_load_start || w_redirect;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and per-cycle control
    always_comb begin
        w_next_state = r_state;
        w_load_start = 1'b0;
        w_redirect   = 1'b0;
        w_issue      = 1'b0;
        w_go_halt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = RUN;
                    w_load_start = 1'b1;
                end
            end
            RUN: begin
                // A redirect wins over an illegal return arriving in the same
                // cycle: that instruction is on the wrong path anyway.
                if (br_taken) begin
                    w_redirect = 1'b1;
                end else if (w_ret_illegal) begin
                    w_next_state = HALT;
                    w_go_halt    = 1'b1;
                end else begin
                    // Hold off while the skid is occupied or the output is
                    // blocked; this keeps at most one fetch in flight beyond
                    // the skid entry, so nothing can overflow.
                    w_issue = !r_skid_valid && !(r_out_valid && stall);
                end
            end
            HALT: begin
                if (start) begin
                    w_next_state = RUN;
                    w_load_start = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Fetch, skid and output datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc         <= START_PC;
            r_pending    <= 1'b0;
            r_pend_pc    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_op    <= '0;
            r_skid_field <= '0;
            r_skid_pc    <= '0;
            r_out_valid  <= 1'b0;
            r_out_op     <= '0;
            r_out_field  <= '0;
            r_out_pc     <= '0;
            r_halt       <= 1'b0;
        end else begin
            if (w_load_start) begin
                r_pc <= START_PC;
            end else if (w_redirect) begin
                r_pc <= br_target;
            end else if (w_issue) begin
                r_pc <= r_pc + 1'b1;  // wraps silently at 2^PC_W
            end

            r_pending <= w_issue;
            if (w_issue) begin
                r_pend_pc <= r_pc;
            end

            if (w_load_start) begin
                r_halt <= 1'b0;
            end else if (w_go_halt) begin
                r_halt <= 1'b1;
            end

            if (w_flush) begin
                r_out_valid  <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (w_out_free) begin
                // The skid entry is older than any return, so it goes first.
                if (r_skid_valid) begin
                    r_out_valid  <= 1'b1;
                    r_out_op     <= r_skid_op;
                    r_out_field  <= r_skid_field;
                    r_out_pc     <= r_skid_pc;
                    r_skid_valid <= w_ret_ok;
                    if (w_ret_ok) begin
                        r_skid_op    <= imem_rdata[8:4];
                        r_skid_field <= imem_rdata[3:0];
                        r_skid_pc    <= r_pend_pc;
                    end
                end else if (w_ret_ok) begin
                    r_out_valid <= 1'b1;
                    r_out_op    <= imem_rdata[8:4];
                    r_out_field <= imem_rdata[3:0];
                    r_out_pc    <= r_pend_pc;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_ret_ok) begin
                r_skid_valid <= 1'b1;
                r_skid_op    <= imem_rdata[8:4];
                r_skid_field <= imem_rdata[3:0];
                r_skid_pc    <= r_pend_pc;
            end
        end
    end

    assign imem_addr = r_pc;
    assign out_valid = r_out_valid;
    assign out_op    = r_out_op;
    assign out_field = r_out_field;
    assign out_pc    = r_out_pc;
    assign halt      = r_halt;
    assign dbg_state = r_state;

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 Parameter PC_W, default 10, program-counter and instruction-address width.
REQ-002 Parameter START_PC, default 0, first fetch address after start.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  pulse; begins fetching from START_PC when in IDLE or HALT.
REQ-006 imem_addr  out  PC_W  instruction-memory address; equals internal pc.
REQ-007 imem_rdata  in  9  instruction; synchronous ROM, valid the cycle after the address is presented.
REQ-008 br_taken  in  1  redirect request from the execute stage.
REQ-009 br_target  in  PC_W  redirect address, sampled when br_taken=1.
REQ-010 stall  in  1  downstream not accepting; transfer occurs when out_valid=1 and stall=0.
REQ-011 out_valid  out  1  out_op, out_field and out_pc hold a decoded instruction.
REQ-012 out_op  out  5  opcode, imem_rdata[8:4], encoded per the team op_code enum (MOV=0 ... ABS=26).
REQ-013 out_field  out  4  operand field, imem_rdata[3:0].
REQ-014 out_pc  out  PC_W  address the presented instruction was fetched from.
REQ-015 halt  out  1  sticky; an illegal opcode (27..31) was fetched.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and HALT; reset enters IDLE.
REQ-017 IDLE -> RUN on start=1, with pc loaded with START_PC; pending and skid are cleared on the same edge.
REQ-018 In RUN, an issue SHALL occur in a cycle when no skid entry is held and not (out_valid=1 and stall=1): pending <= 1, pend_pc <= pc, pc <= pc+1.
REQ-019 In a non-issue RUN cycle, pc SHALL hold and pending SHALL clear.
REQ-020 pc SHALL wrap from 2^PC_W-1 to 0 with no flag.
REQ-021 When a pending instruction returns, it SHALL load the output register if the output register is empty or transferring this cycle; otherwise it SHALL load the 1-entry skid buffer.
REQ-022 A skid entry SHALL move to the output register on the first transfer cycle, ahead of any newer return.
REQ-023 Order SHALL be preserved; no instruction is dropped or duplicated under any stall pattern.
REQ-024 Output registers SHALL hold their values while out_valid=1 and stall=1.
REQ-025 out_valid SHALL clear after a transfer when no replacement is available.
REQ-026 br_taken=1 in RUN SHALL set pc <= br_target and clear pending, skid and out_valid on the same edge.
REQ-027 br_taken SHALL override issue, stall and an illegal-opcode return in the same cycle.
REQ-028 A transfer occurring in the br_taken cycle still counts; squashing it is the downstream stage's duty.
REQ-029 br_taken SHALL be ignored in IDLE and HALT.
REQ-030 An illegal opcode reaching the output-register or skid load point SHALL NOT be loaded.
REQ-031 On an illegal-opcode return, the FSM SHALL go to HALT, set halt=1 and clear pending; any earlier valid instructions still drain normally.
REQ-032 In HALT, no issue occurs; start=1 SHALL clear halt, clear out_valid and skid, load pc=START_PC and enter RUN.
REQ-033 start SHALL be ignored in RUN.
REQ-034 Latency: start sampled on edge E -> imem_addr=START_PC after E, out_valid=1 with out_pc=START_PC after edge E+2, then one instruction per cycle without stall.
REQ-035 Redirect latency: br_taken sampled on edge E -> imem_addr=br_target after E, out_valid=0 after E+1, out_pc=br_target after E+2.

Reset
REQ-036 reset=1 SHALL immediately force state=IDLE, pc=START_PC, pending=0, skid empty, out_valid=0, out_op=0, out_field=0, out_pc=0, halt=0, regardless of clk.
REQ-037 Reset asserted mid-operation SHALL discard all in-flight instructions; after release the block waits in IDLE for start.

Verification
REQ-038 ROM[0..3]={0x0B3,0x0C1,0x125,0x0A7}; pulse start -> out_pc 0,1,2,3 on consecutive cycles with (op,field) = (0x0B,3),(0x0C,1),(0x12,5),(0x0A,7).
REQ-039 Hold stall=1 for 3 cycles while out_pc=1 -> outputs frozen, skid holds pc 2, no issue; after release, pc 2 then pc 3 are presented with none lost or repeated.
REQ-040 br_taken=1 with br_target=0x040 while stall=1 and skid full -> out_valid=0 next cycle, then out_pc=0x040 two cycles after the branch.
REQ-041 ROM[5]=0x1B0 -> instructions 0-4 presented, halt=1, pc 5 never presented; a later start restarts at pc 0 with halt=0.
REQ-042 PC_W=4, START_PC=14, ROM filled with legal opcodes -> out_pc sequence 14,15,0,1.
REQ-043 Assert reset asynchronously between clock edges during RUN with out_valid=1 -> out_valid and halt drop to 0 before the next edge; the block then stays in IDLE until start.
